logic_pipe_unit: RTL and testbench

Parametrised, pipelined bitwise logic unit. It generalises the lab's single-bit gate set to WIDTH-bit operands and adds an op-select, valid/ready flow control, status flags and a transaction counter. It sits between a stimulus/producer stage and a consumer, and is the standard gate-level datapath block for later lab designs.

---
 rtl/logic_pkg.sv | 47 ++++
 rtl/logic_core.sv | 46 ++++
 rtl/logic_pipe_unit.sv | 170 +++++++++++++++++
 tb/tb_logic_pipe_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_pkg.sv
// Shared types and the bitwise evaluation function for the logic pipe.
// Operands are widened to MAX_W so one function serves every WIDTH.
package logic_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NOT  = 3'd2,
        OP_XOR  = 3'd3,
        OP_NAND = 3'd4,
        OP_NOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_RSVD = 3'd7
    } op_t;

    typedef struct packed {
        logic [MAX_W-1:0] y;
        logic             err;
    } eval_t;

    function automatic eval_t logic_eval(
        input op_t              op,
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b
    );
        eval_t r;
        r.y   = '0;
        r.err = 1'b0;
        unique case (op)
            OP_AND:  r.y = a & b;
            OP_OR:   r.y = a | b;
            OP_NOT:  r.y = ~a;
            OP_XOR:  r.y = a ^ b;
            OP_NAND: r.y = ~(a & b);
            OP_NOR:  r.y = ~(a | b);
            OP_XNOR: r.y = ~(a ^ b);
            OP_RSVD: begin
                r.y   = '0;
                r.err = 1'b1;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_core.sv
// Combinational op evaluation plus zero/parity flags at WIDTH bits.
// Sits between the S1 and S2 registers of logic_pipe_unit.
import logic_pkg::*;

module logic_core #(
    parameter int WIDTH = 8
) (
    input  op_t              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             parity,
    output logic             err
);

    logic [MAX_W-1:0] a_ext;
    logic [MAX_W-1:0] b_ext;
    eval_t            res;

    // Widen operands, evaluate, keep only the live WIDTH result bits
    always_comb begin
        a_ext            = '0;
        b_ext            = '0;
        a_ext[WIDTH-1:0] = a;
        b_ext[WIDTH-1:0] = b;
        res              = logic_eval(op, a_ext, b_ext);
        y                = res.y[WIDTH-1:0];
        err              = res.err;
    end

    // Flags derive from the truncated result so they always match y
    always_comb begin
        zero   = (y == '0);
        parity = ^y;
    end

    // Upper bits of the widened result are discarded by design
    generate
        if (WIDTH < MAX_W) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^res.y[MAX_W-1:WIDTH];
        end
    endgenerate

endmodule

// File: rtl/logic_pipe_unit.sv
// Two-stage valid/ready bitwise logic unit with status flags and a
// saturating completed-operation counter.
import logic_pkg::*;

module logic_pipe_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             parity,
    output logic             err,
    output logic [CNT_W-1:0] op_count,
    input  logic             count_clr
);

    logic             adv1;
    logic             adv2;
    logic             fire;

    logic             s1_valid_q;
    logic             s1_valid_d;
    op_t              s1_op_q;
    op_t              s1_op_d;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_a_d;
    logic [WIDTH-1:0] s1_b_q;
    logic [WIDTH-1:0] s1_b_d;

    logic             out_valid_q;
    logic             out_valid_d;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] y_d;
    logic             zero_q;
    logic             zero_d;
    logic             parity_q;
    logic             parity_d;
    logic             err_q;
    logic             err_d;

    logic [WIDTH-1:0] core_y;
    logic             core_zero;
    logic             core_parity;
    logic             core_err;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Ready chain: a stage advances when it is empty or downstream moves
    always_comb begin
        adv2     = !out_valid_q || out_ready;
        adv1     = !s1_valid_q || adv2;
        in_ready = adv1;
        fire     = out_valid_q && out_ready;
    end

    // S1 next state: capture the producer's op/operands when advancing
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        if (adv1) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_op_d = op_t'(op);
                s1_a_d  = a;
                s1_b_d  = b;
            end
        end
    end

    // S1 registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= OP_AND;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
        end
    end

    logic_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op     (s1_op_q),
        .a      (s1_a_q),
        .b      (s1_b_q),
        .y      (core_y),
        .zero   (core_zero),
        .parity (core_parity),
        .err    (core_err)
    );

    // S2 next state: result and flags load together, hold on stall
    always_comb begin
        out_valid_d = out_valid_q;
        y_d         = y_q;
        zero_d      = zero_q;
        parity_d    = parity_q;
        err_d       = err_q;
        if (adv2) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                y_d      = core_y;
                zero_d   = core_zero;
                parity_d = core_parity;
                err_d    = core_err;
            end
        end
    end

    // S2 registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            y_q         <= '0;
            zero_q      <= 1'b0;
            parity_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            zero_q      <= zero_d;
            parity_q    <= parity_d;
            err_q       <= err_d;
        end
    end

    // Counter next state: clear wins, otherwise saturating increment
    always_comb begin
        count_d = count_q;
        if (count_clr) begin
            count_d = '0;
        end else if (fire && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Completed-operation counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign zero      = zero_q;
    assign parity    = parity_q;
    assign err       = err_q;
    assign op_count  = count_q;

endmodule

// File: tb/tb_logic_pipe_unit.sv
// Directed bench for logic_pipe_unit: an 8-bit/16-bit-counter instance
// and a 1-bit/3-bit-counter instance share one clock.
module tb_logic_pipe_unit;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
        logic       z;
        logic       p;
        logic       e;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       rst1_n;

    logic       iv8, ir8, ov8, or8, z8, p8, e8, clr8;
    logic [2:0] op8;
    logic [7:0] a8, b8, y8;
    logic [15:0] cnt8;

    logic       iv1, ir1, ov1, or1, y1, z1, p1, e1, clr1, a1, b1;
    logic [2:0] op1;
    logic [2:0] cnt1;

    int errors = 0;
    int checks = 0;

    vec_t tbl[$];
    vec_t v1q[$];
    vec_t sq[$];
    vec_t blank;
    logic [7:0] got[$];
    logic [3:0] tt[7];

    logic_pipe_unit #(.WIDTH(8), .CNT_W(16)) u_d8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8), .in_ready(ir8),
        .op(op8), .a(a8), .b(b8),
        .out_valid(ov8), .out_ready(or8),
        .y(y8), .zero(z8), .parity(p8), .err(e8),
        .op_count(cnt8), .count_clr(clr8)
    );

    logic_pipe_unit #(.WIDTH(1), .CNT_W(3)) u_d1 (
        .clk(clk), .rst_n(rst1_n),
        .in_valid(iv1), .in_ready(ir1),
        .op(op1), .a(a1), .b(b1),
        .out_valid(ov1), .out_ready(or1),
        .y(y1), .zero(z1), .parity(p1), .err(e1),
        .op_count(cnt1), .count_clr(clr1)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] o, input logic [7:0] aa,
                                input logic [7:0] bb, input logic [7:0] yy,
                                input logic zz, input logic pp,
                                input logic ee);
        vec_t v;
        v.op = o; v.a = aa; v.b = bb; v.y = yy;
        v.z = zz; v.p = pp; v.e = ee;
        return v;
    endfunction

    task automatic drv(input bit w1, input logic v, input vec_t t);
        if (w1) begin
            iv1 = v; op1 = t.op; a1 = t.a[0]; b1 = t.b[0];
        end else begin
            iv8 = v; op8 = t.op; a8 = t.a; b8 = t.b;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Stream tbl with out_ready high; vector k is due two cycles later
    task automatic run_tbl(input bit w1);
        int n;
        logic [7:0] yy;
        logic ov, zz, pp, ee;
        n = tbl.size();
        for (int k = 0; k < n + 2; k++) begin
            if (k < n) drv(w1, 1'b1, tbl[k]);
            else drv(w1, 1'b0, blank);
            #1;
            ov = w1 ? ov1 : ov8;
            yy = w1 ? {7'b0, y1} : y8;
            zz = w1 ? z1 : z8;
            pp = w1 ? p1 : p8;
            ee = w1 ? e1 : e8;
            if (k >= 2) begin
                chk($sformatf("w%0d v%0d out_valid", w1, k-2), 64'(ov), 64'(1));
                if (w1) chk($sformatf("w1 v%0d y", k-2), 64'(yy), 64'(tbl[k-2].y[0]));
                else chk($sformatf("w8 v%0d y", k-2), 64'(yy), 64'(tbl[k-2].y));
                chk($sformatf("w%0d v%0d zero", w1, k-2), 64'(zz), 64'(tbl[k-2].z));
                chk($sformatf("w%0d v%0d parity", w1, k-2), 64'(pp), 64'(tbl[k-2].p));
                chk($sformatf("w%0d v%0d err", w1, k-2), 64'(ee), 64'(tbl[k-2].e));
            end else begin
                chk($sformatf("w%0d fill%0d out_valid", w1, k), 64'(ov), 64'(0));
            end
            cyc();
        end
    endtask

    initial begin
        int sent;
        logic acc, prev_hold;
        logic [7:0] prev_y;
        logic [1:0] ab;

        blank = mk(3'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0; rst1_n = 1'b0;
        iv8 = 0; op8 = 0; a8 = 0; b8 = 0; or8 = 1; clr8 = 0;
        iv1 = 0; op1 = 0; a1 = 0; b1 = 0; or1 = 1; clr1 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        chk("rst out_valid8", 64'(ov8), 64'(0));
        chk("rst y8", 64'(y8), 64'(0));
        chk("rst flags8", 64'({z8, p8, e8}), 64'(0));
        chk("rst count8", 64'(cnt8), 64'(0));
        chk("rst out_valid1", 64'(ov1), 64'(0));
        chk("rst count1", 64'(cnt1), 64'(0));
        rst_n = 1'b1; rst1_n = 1'b1;
        #1;
        chk("post-rst in_ready8", 64'(ir8), 64'(1));
        chk("post-rst in_ready1", 64'(ir1), 64'(1));
        cyc();

        // WIDTH=1 truth tables, indexed by {a,b}
        tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0011;
        tt[3] = 4'b0110; tt[4] = 4'b0111; tt[5] = 4'b0001;
        tt[6] = 4'b1001;
        for (int o = 0; o < 7; o++) begin
            for (int i = 0; i < 4; i++) begin
                logic yb;
                ab = 2'(i);
                yb = tt[o][ab];
                v1q.push_back(mk(3'(o), {7'b0, ab[1]}, {7'b0, ab[0]},
                                 {7'b0, yb}, !yb, yb, 1'b0));
            end
        end
        v1q.push_back(mk(3'd7, 8'h01, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1));
        tbl = v1q;
        run_tbl(1'b1);
        chk("w1 count saturated", 64'(cnt1), 64'(7));

        // WIDTH=8 vectors
        tbl.delete();
        tbl.push_back(mk(3'd0, 8'hC3, 8'h5A, 8'h42, 0, 0, 0));
        tbl.push_back(mk(3'd1, 8'hC3, 8'h5A, 8'hDB, 0, 0, 0));
        tbl.push_back(mk(3'd2, 8'hC3, 8'h5A, 8'h3C, 0, 0, 0));
        tbl.push_back(mk(3'd3, 8'hC3, 8'h5A, 8'h99, 0, 0, 0));
        tbl.push_back(mk(3'd4, 8'hC3, 8'h5A, 8'hBD, 0, 0, 0));
        tbl.push_back(mk(3'd5, 8'hC3, 8'h5A, 8'h24, 0, 0, 0));
        tbl.push_back(mk(3'd6, 8'hC3, 8'h5A, 8'h66, 0, 0, 0));
        tbl.push_back(mk(3'd0, 8'hFF, 8'h01, 8'h01, 0, 1, 0));
        tbl.push_back(mk(3'd0, 8'hF0, 8'h0F, 8'h00, 1, 0, 0));
        tbl.push_back(mk(3'd7, 8'hFF, 8'hFF, 8'h00, 1, 0, 1));
        tbl.push_back(mk(3'd3, 8'hA5, 8'h0F, 8'hAA, 0, 0, 0));
        tbl.push_back(mk(3'd1, 8'h01, 8'h00, 8'h01, 0, 1, 0));
        tbl.push_back(mk(3'd2, 8'hFF, 8'h12, 8'h00, 1, 0, 0));
        run_tbl(1'b0);
        chk("w8 count after table", 64'(cnt8), 64'(13));

        // Stall: out_ready low for the first 4 cycles
        sq.push_back(mk(3'd3, 8'h11, 8'h22, 8'h33, 0, 0, 0));
        sq.push_back(mk(3'd0, 8'hF0, 8'h3C, 8'h30, 0, 0, 0));
        sq.push_back(mk(3'd1, 8'h01, 8'h80, 8'h81, 0, 0, 0));
        sq.push_back(mk(3'd2, 8'h0F, 8'h00, 8'hF0, 0, 0, 0));
        sq.push_back(mk(3'd5, 8'h00, 8'h00, 8'hFF, 0, 0, 0));
        sent = 0;
        prev_hold = 1'b0;
        prev_y = 8'h00;
        for (int c = 0; c < 40 && got.size() < 5; c++) begin
            or8 = (c >= 4);
            if (sent < 5) drv(1'b0, 1'b1, sq[sent]);
            else drv(1'b0, 1'b0, blank);
            #1;
            if (c == 0) chk("stall in_ready open", 64'(ir8), 64'(1));
            if (!or8 && sent == 2)
                chk($sformatf("stall in_ready low c%0d", c), 64'(ir8), 64'(0));
            if (prev_hold)
                chk($sformatf("stall y hold c%0d", c), 64'(y8), 64'(prev_y));
            prev_hold = ov8 && !or8;
            prev_y = y8;
            if (ov8 && or8) got.push_back(y8);
            acc = iv8 && ir8;
            @(posedge clk);
            if (acc) sent++;
            @(negedge clk);
        end
        chk("stall received count", 64'(got.size()), 64'(5));
        for (int i = 0; i < 5; i++) begin
            if (i < got.size())
                chk($sformatf("stall order %0d", i), 64'(got[i]), 64'(sq[i].y));
        end
        #1;
        chk("stall no duplicate", 64'(ov8), 64'(0));
        chk("w8 count after stall", 64'(cnt8), 64'(18));

        // Counter saturation and clear on the 1-bit / 3-bit instance
        rst1_n = 1'b0;
        cyc();
        rst1_n = 1'b1;
        chk("w1 count after reset", 64'(cnt1), 64'(0));
        tbl.delete();
        for (int i = 0; i < 9; i++) tbl.push_back(v1q[i]);
        run_tbl(1'b1);
        chk("w1 count sticks at 7", 64'(cnt1), 64'(7));
        drv(1'b1, 1'b1, v1q[3]);
        cyc();
        drv(1'b1, 1'b0, blank);
        cyc();
        chk("clr out_valid", 64'(ov1), 64'(1));
        clr1 = 1'b1;
        cyc();
        clr1 = 1'b0;
        chk("clr beats increment", 64'(cnt1), 64'(0));
        chk("clr drained", 64'(ov1), 64'(0));

        // Reset with two ops in flight
        or8 = 1'b1;
        drv(1'b0, 1'b1, mk(3'd0, 8'hFF, 8'h0F, 8'h0F, 0, 0, 0));
        cyc();
        drv(1'b0, 1'b1, mk(3'd1, 8'h30, 8'h03, 8'h33, 0, 0, 0));
        cyc();
        drv(1'b0, 1'b0, blank);
        chk("inflight out_valid", 64'(ov8), 64'(1));
        rst_n = 1'b0;
        cyc();
        chk("midrst out_valid", 64'(ov8), 64'(0));
        chk("midrst count", 64'(cnt8), 64'(0));
        chk("midrst y", 64'(y8), 64'(0));
        rst_n = 1'b1;
        #1;
        chk("midrst in_ready", 64'(ir8), 64'(1));
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("midrst no stale %0d", i), 64'(ov8), 64'(0));
        end
        chk("midrst count stays", 64'(cnt8), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
